// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, one-hot
// operation indices, inter-stage bus structs and divider FSM states.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 322;
    localparam int ES_TO_MS_BUS_WD = 271;
    localparam int ES_TO_DS_BUS_WD = 38;
    localparam int ALE_BIT         = 6;

    // alu_op bit indices
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_OR    = 5;
    localparam int ALU_NOR   = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LU12I = 11;

    // md_op bit indices
    localparam int MD_MUL   = 0;
    localparam int MD_MULH  = 1;
    localparam int MD_MULHU = 2;
    localparam int MD_DIV   = 3;
    localparam int MD_MOD   = 4;
    localparam int MD_DIVU  = 5;
    localparam int MD_MODU  = 6;

    // store_op / load_op bit indices
    localparam int ST_B  = 0;
    localparam int ST_H  = 1;
    localparam int ST_W  = 2;
    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;
    localparam int LD_LL = 5;

    typedef struct packed {
        logic [63:0] csr_vec;
        logic [63:0] csr_bus;
        logic [11:0] alu_op;
        logic [6:0]  md_op;
        logic [5:0]  load_op;
        logic [2:0]  store_op;
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] st_data;
        logic [31:0] pc;
        logic [31:0] inst;
    } ds_es_t;

    typedef struct packed {
        logic [63:0] csr_vec;
        logic [63:0] csr_bus;
        logic [5:0]  load_op;
        logic [2:0]  store_op;
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] es_result;
        logic [31:0] src1;
        logic [31:0] pc;
        logic [31:0] inst;
    } es_ms_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

    // Magnitude of a possibly-signed operand.
    function automatic logic [31:0] mag(input logic [31:0] x,
                                        input logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Data-SRAM request bus driven by the execute stage.
// master: exe_stage drives en/we/addr/wdata; slave: memory side.
interface exe_stage_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata
    );

    modport slave (
        input data_sram_en,
        input data_sram_we,
        input data_sram_addr,
        input data_sram_wdata
    );
endinterface

// File: rtl/exe_stage_div_unit.sv
// Radix-2 restoring divider, 32 iterations, IDLE -> RUN -> DONE.
// Ports: clk, reset, flush_i, start_i, hold_i (keep DONE), signed_i,
// a_i/b_i operands -> busy_o, done_o, q_o quotient, r_o remainder.
module div_unit
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic        hold_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] q_o,
    output logic [31:0] r_o
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] dvd_q, dvd_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        zero_q, zero_d;

    logic [32:0] part;
    logic [32:0] diff;
    logic        ge;
    logic        unused_div;

    // Partial remainder with the next dividend bit shifted in.
    assign part = {rem_q, quo_q[31]};
    assign diff = part - {1'b0, dsr_q};
    assign ge   = part >= {1'b0, dsr_q};

    assign unused_div = diff[32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        dvd_d   = dvd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    state_d = DIV_RUN;
                    cnt_d   = 5'd0;
                    quo_d   = mag(a_i, signed_i);
                    rem_d   = 32'd0;
                    dsr_d   = mag(b_i, signed_i);
                    dvd_d   = a_i;
                    negq_d  = signed_i & (a_i[31] ^ b_i[31]);
                    negr_d  = signed_i & a_i[31];
                    zero_d  = (b_i == 32'd0);
                end
            end
            DIV_RUN: begin
                rem_d = ge ? diff[31:0] : part[31:0];
                quo_d = {quo_q[30:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (!hold_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        if (flush_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dsr_q   <= 32'd0;
            dvd_q   <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            dvd_q   <= dvd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o = (state_q == DIV_RUN);
    assign done_o = (state_q == DIV_DONE);

    // Divide by zero bypasses sign correction: q all ones, r = dividend.
    assign q_o = zero_q ? 32'hFFFF_FFFF
               : (negq_q ? (32'd0 - quo_q) : quo_q);
    assign r_o = zero_q ? dvd_q
               : (negr_q ? (32'd0 - rem_q) : rem_q);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, single-cycle MUL, iterative DIV, SRAM requests.
// Ports: clk/reset/flush, stall vector, ms_except_en, stallreq_ex,
// ds_to_es_bus in, es_to_ms_bus/es_to_ds_bus out, dsram request bus.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [5:0]                 stall,
    input  logic                       ms_except_en,
    output logic                       stallreq_ex,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
    exe_stage_if.master                dsram
);

    ds_es_t es_q, es_d;

    always_comb begin
        es_d = es_q;
        if (reset || flush) begin
            es_d = '0;
        end else if (stall[2] && !stall[3]) begin
            es_d = '0;
        end else if (!stall[2]) begin
            es_d = ds_es_t'(ds_to_es_bus);
        end
    end

    always_ff @(posedge clk) begin
        es_q <= es_d;
    end

    logic [31:0] a, b;
    logic [4:0]  sh;

    assign a  = es_q.src1;
    assign b  = es_q.src2;
    assign sh = es_q.src2[4:0];

    logic [31:0] alu_res;

    always_comb begin
        alu_res = 32'd0;
        unique case (1'b1)
            es_q.alu_op[ALU_ADD]:   alu_res = a + b;
            es_q.alu_op[ALU_SUB]:   alu_res = a - b;
            es_q.alu_op[ALU_SLT]:
                alu_res = {31'd0, $signed(a) < $signed(b)};
            es_q.alu_op[ALU_SLTU]:  alu_res = {31'd0, a < b};
            es_q.alu_op[ALU_AND]:   alu_res = a & b;
            es_q.alu_op[ALU_OR]:    alu_res = a | b;
            es_q.alu_op[ALU_NOR]:   alu_res = ~(a | b);
            es_q.alu_op[ALU_XOR]:   alu_res = a ^ b;
            es_q.alu_op[ALU_SLL]:   alu_res = a << sh;
            es_q.alu_op[ALU_SRL]:   alu_res = a >> sh;
            es_q.alu_op[ALU_SRA]:   alu_res = $signed(a) >>> sh;
            es_q.alu_op[ALU_LU12I]: alu_res = b;
            default:                alu_res = 32'd0;
        endcase
    end

    logic [63:0] prod_s, prod_u;
    logic [31:0] mul_res;
    logic        mul_op;

    assign prod_s = $signed({{32{a[31]}}, a})
                  * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign mul_op = |es_q.md_op[MD_MULHU:MD_MUL];

    always_comb begin
        mul_res = prod_u[63:32];
        if (es_q.md_op[MD_MUL]) begin
            mul_res = prod_s[31:0];
        end else if (es_q.md_op[MD_MULH]) begin
            mul_res = prod_s[63:32];
        end
    end

    logic        div_op, div_signed, div_want_q;
    logic        div_busy, div_done;
    logic [31:0] div_q, div_r;

    assign div_op     = |es_q.md_op[MD_MODU:MD_DIV];
    assign div_signed = es_q.md_op[MD_DIV] | es_q.md_op[MD_MOD];
    assign div_want_q = es_q.md_op[MD_DIV] | es_q.md_op[MD_DIVU];

    div_unit u_div (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (flush),
        .start_i  (div_op),
        .hold_i   (stall[2]),
        .signed_i (div_signed),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .q_o      (div_q),
        .r_o      (div_r)
    );

    assign stallreq_ex = div_op & ~div_done;

    logic        mem_op, is_half, is_word, ale, req;
    logic [31:0] addr;
    logic [3:0]  we_raw;
    logic [31:0] wdata;

    assign mem_op  = (|es_q.load_op) | (|es_q.store_op);
    assign addr    = a + b;
    assign is_half = es_q.store_op[ST_H] | es_q.load_op[LD_H]
                   | es_q.load_op[LD_HU];
    assign is_word = es_q.store_op[ST_W] | es_q.load_op[LD_W]
                   | es_q.load_op[LD_LL];
    assign ale     = mem_op & ((is_half & addr[0])
                   | (is_word & (addr[1] | addr[0])));
    // An excepting older instruction or a flush kills this request.
    assign req     = mem_op & ~ale & ~ms_except_en & ~flush;

    always_comb begin
        we_raw = 4'b0000;
        wdata  = es_q.st_data;
        unique case (1'b1)
            es_q.store_op[ST_B]: begin
                we_raw = 4'b0001 << addr[1:0];
                wdata  = {4{es_q.st_data[7:0]}};
            end
            es_q.store_op[ST_H]: begin
                we_raw = 4'b0011 << addr[1:0];
                wdata  = {2{es_q.st_data[15:0]}};
            end
            es_q.store_op[ST_W]: begin
                we_raw = 4'b1111;
            end
            default: we_raw = 4'b0000;
        endcase
    end

    assign dsram.data_sram_en    = req;
    assign dsram.data_sram_we    = req ? we_raw : 4'b0000;
    assign dsram.data_sram_addr  = addr;
    assign dsram.data_sram_wdata = wdata;

    logic [31:0] es_result;

    always_comb begin
        es_result = alu_res;
        if (mem_op) begin
            es_result = addr;
        end else if (div_op) begin
            es_result = div_want_q ? div_q : div_r;
        end else if (mul_op) begin
            es_result = mul_res;
        end
    end

    es_ms_t ms_o;

    always_comb begin
        ms_o               = '0;
        ms_o.csr_vec       = es_q.csr_vec;
        ms_o.csr_vec[ALE_BIT] = es_q.csr_vec[ALE_BIT] | ale;
        ms_o.csr_bus       = es_q.csr_bus;
        ms_o.load_op       = es_q.load_op;
        ms_o.store_op      = es_q.store_op;
        ms_o.reg_we        = es_q.reg_we;
        ms_o.dest          = es_q.dest;
        ms_o.es_result     = es_result;
        ms_o.src1          = es_q.src1;
        ms_o.pc            = es_q.pc;
        ms_o.inst          = es_q.inst;
    end

    assign es_to_ms_bus = ms_o;
    assign es_to_ds_bus = {es_q.reg_we & ~stallreq_ex,
                           es_q.dest, es_result};

    logic unused_es;
    assign unused_es = &{1'b0, stall[5:4], stall[1:0],
                         div_busy, prod_u[31:0]};

endmodule
